// File: rtl/cam_pkg.sv
// Shared encodings and default geometry for the OV7670 multi-format capture path.
package cam_pkg;

    localparam logic [1:0] MODE_RGB444 = 2'd0;
    localparam logic [1:0] MODE_RGB565 = 2'd1;
    localparam logic [1:0] MODE_Y8     = 2'd2;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd1;
    localparam logic [1:0] ST_ACTIVE     = 2'd2;

    localparam int OV_H_ACT = 640;
    localparam int OV_V_ACT = 480;

endpackage

// File: rtl/cam_pix_pack.sv
// Combinational byte-pair to 16-bit pixel formatter; byte a arrives first on the bus.
module cam_pix_pack
    import cam_pkg::*;
(
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [1:0]  mode,
    output logic [15:0] pix
);

    always_comb begin
        // NOTE: pix gets a default before the case so every path drives it and no latch is inferred.
        pix = {a, b};
        case (mode)
            MODE_RGB444: pix = {4'b0, a[7:4], a[2:0], b[7], b[4:1]};
            MODE_RGB565: pix = {a, b};
            MODE_Y8:     pix = {8'b0, a};
            default:     pix = {a, b};
        endcase
    end

endmodule

// File: rtl/cam_capture_multi.sv
// OV7670 byte-stream capture: frame FSM, byte pairing, decimation and sequential BRAM writes.
module cam_capture_multi
    import cam_pkg::*;
#(
    parameter int H_ACT  = OV_H_ACT,
    parameter int V_ACT  = OV_V_ACT,
    parameter int DEC    = 1,
    parameter int ADDR_W = 19
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cam_done,
    input  logic              i_arm,
    input  logic              i_continuous,
    input  logic              i_stop,
    input  logic [1:0]        i_mode,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_D,
    output logic              o_wr,
    output logic [15:0]       o_pix_data,
    output logic [ADDR_W-1:0] o_pix_addr,
    output logic              o_frame_done,
    output logic [15:0]       o_frame_cnt,
    output logic              o_fmt_err,
    output logic              o_busy
);

    localparam int COL_W = $clog2(H_ACT + 1);
    localparam int ROW_W = $clog2(V_ACT + 2);
    localparam int LB_W  = $clog2(2 * H_ACT + 2);

    // Counters saturate one past their legal range so overlong lines/frames stay detectable.
    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(H_ACT);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(V_ACT);
    localparam logic [ROW_W-1:0] ROW_SAT  = ROW_W'(V_ACT + 1);
    localparam logic [LB_W-1:0]  LB_FULL  = LB_W'(2 * H_ACT);
    localparam logic [LB_W-1:0]  LB_SAT   = LB_W'(2 * H_ACT + 1);
    localparam logic [COL_W-1:0] COL_MASK = COL_W'(DEC - 1);
    localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'(DEC - 1);

    logic [1:0]        state;
    logic              vsync_q, href_q, phase, stop_pend, cont_q;
    logic [1:0]        mode_q;
    logic [7:0]        byte_a;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [LB_W-1:0]   line_bytes;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       pix;

    logic vs_fall, vs_rise, href_rise, href_fall, pix_valid, keep;

    assign vs_fall   = vsync_q & ~i_vsync;
    assign vs_rise   = ~vsync_q & i_vsync;
    assign href_rise = ~href_q & i_href;
    assign href_fall = href_q & ~i_href;

    // Byte B completes a pixel; an HREF rising edge always restarts pairing at byte A.
    assign pix_valid = (state == ST_ACTIVE) & i_href & ~href_rise & phase;
    assign keep      = pix_valid & (col < COL_MAX) & (row < ROW_MAX)
                     & ((col & COL_MASK) == '0) & ((row & ROW_MASK) == '0);

    assign o_busy = (state != ST_IDLE);

    cam_pix_pack u_pix_pack (
        .a    (byte_a),
        .b    (i_D),
        .mode (mode_q),
        .pix  (pix)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            phase        <= 1'b0;
            stop_pend    <= 1'b0;
            cont_q       <= 1'b0;
            mode_q       <= MODE_RGB444;
            byte_a       <= '0;
            col          <= '0;
            row          <= '0;
            line_bytes   <= '0;
            addr         <= '0;
            o_wr         <= 1'b0;
            o_pix_data   <= '0;
            o_pix_addr   <= '0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= '0;
            o_fmt_err    <= 1'b0;
        end else begin
            // NOTE: all state updates use non-blocking assignments; pulses default low each cycle.
            vsync_q      <= i_vsync;
            href_q       <= i_href;
            o_wr         <= 1'b0;
            o_frame_done <= 1'b0;

            if (!i_cam_done) begin
                state     <= ST_IDLE;
                stop_pend <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_arm && !i_stop) begin
                            state       <= ST_WAIT_FRAME;
                            mode_q      <= i_mode;
                            cont_q      <= i_continuous;
                            o_frame_cnt <= '0;
                            o_fmt_err   <= 1'b0;
                            stop_pend   <= 1'b0;
                        end
                    end
                    ST_WAIT_FRAME: begin
                        if (i_stop) begin
                            state <= ST_IDLE;
                        end else if (vs_fall) begin
                            state      <= ST_ACTIVE;
                            mode_q     <= i_mode;
                            cont_q     <= i_continuous;
                            phase      <= 1'b0;
                            col        <= '0;
                            row        <= '0;
                            line_bytes <= '0;
                            addr       <= '0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (i_stop) stop_pend <= 1'b1;
                        if (vs_rise) begin
                            if (row == ROW_MAX) begin
                                o_frame_done <= 1'b1;
                                o_frame_cnt  <= o_frame_cnt + 16'd1;
                            end else begin
                                o_fmt_err <= 1'b1;
                            end
                            state     <= (cont_q && !stop_pend && !i_stop) ? ST_WAIT_FRAME : ST_IDLE;
                            stop_pend <= 1'b0;
                        end else begin
                            if (i_href) begin
                                if (href_rise) begin
                                    byte_a     <= i_D;
                                    phase      <= 1'b1;
                                    line_bytes <= LB_W'(1);
                                    col        <= '0;
                                end else begin
                                    if (line_bytes != LB_SAT) line_bytes <= line_bytes + 1'b1;
                                    phase <= ~phase;
                                    if (!phase) byte_a <= i_D;
                                    else if (col != COL_MAX) col <= col + 1'b1;
                                end
                            end else if (href_fall) begin
                                if (line_bytes != LB_FULL) o_fmt_err <= 1'b1;
                                if (row != ROW_SAT) row <= row + 1'b1;
                            end
                            if (keep) begin
                                o_wr       <= 1'b1;
                                o_pix_data <= pix;
                                o_pix_addr <= addr;
                                addr       <= addr + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/cam_capture_multi.md
Name: cam_capture_multi

Overview:
Parametrised successor to the fixed RGB444 pixel capture stage in the camera path. It samples OV7670 byte-stream video (VSYNC/HREF/D[7:0]) once camera init is done. It assembles byte pairs into pixels in a runtime-selected format, optionally decimates by a power of two, and writes pixels sequentially to the frame BRAM. Adds single-shot/continuous capture, frame counting and stream-format error detection. It sits between the camera I/O pins and the frame buffer, clocked by the camera pixel clock.

Parameters:
H_ACT, 640, active pixels per line (each pixel is 2 bytes)
V_ACT, 480, active lines per frame
DEC, 1, decimation factor in both axes; legal values 1, 2, 4
ADDR_W, 19, BRAM address width; must satisfy 2^ADDR_W >= (H_ACT/DEC)*(V_ACT/DEC)

Ports:
i_clk  in  1  camera pixel clock (PCLK); the only clock
i_rst  in  1  synchronous, active-high reset
i_cam_done  in  1  camera init complete; capture is held off while low
i_arm  in  1  1-cycle pulse: request one frame (single-shot) or start continuous capture
i_continuous  in  1  1 = capture every frame after arm; 0 = one frame then stop
i_stop  in  1  1-cycle pulse: finish current frame, then return to IDLE
i_mode  in  2  0 = RGB444, 1 = RGB565, 2 = Y8 (YUYV luma), 3 = reserved (treated as 1)
i_vsync  in  1  frame sync, high between frames
i_href  in  1  line valid
i_D  in  8  pixel byte
o_wr  out  1  BRAM write strobe
o_pix_data  out  16  pixel, zero-extended to 16 bits
o_pix_addr  out  ADDR_W  BRAM write address
o_frame_done  out  1  1-cycle pulse after a complete frame is written
o_frame_cnt  out  16  completed frames since arm, wraps at 65535 -> 0
o_fmt_err  out  1  sticky stream-format error
o_busy  out  1  high in WAIT_FRAME and ACTIVE

Behaviour:
- Reset: state IDLE; every output is 0; internal counters are 0.
- Clock and reset are fixed as stated: one clock (i_clk, the camera PCLK) with a synchronous, active-high reset (i_rst).
- i_mode and i_continuous are latched at arm and at each frame start; changes mid-frame are ignored.
- FSM:
  - IDLE -> WAIT_FRAME on i_arm while i_cam_done=1. i_arm is ignored while i_cam_done=0.
  - Arm clears o_frame_cnt and o_fmt_err.
  - WAIT_FRAME -> ACTIVE on a falling edge of i_vsync (registered vsync 1 -> current 0). Row, column, byte-phase and address counters are cleared.
  - ACTIVE -> frame end on a rising edge of i_vsync.
    - If rows captured == V_ACT: pulse o_frame_done and increment o_frame_cnt.
    - Otherwise: set o_fmt_err, no done pulse, no count increment.
  - After frame end: go to WAIT_FRAME if continuous and no stop is pending; otherwise go to IDLE.
  - i_stop sets a pending flag that is consumed at the next frame end. In IDLE or WAIT_FRAME, i_stop forces IDLE immediately.
  - i_cam_done falling in any state forces IDLE with no done pulse.
- Byte pairing, ACTIVE only, while i_href=1: the byte phase toggles each cycle.
  - Phase 0: latch byte A.
  - Phase 1: byte B completes a pixel.
  - Byte phase resets at every HREF rising edge.
- Pixel formats (byte A first, then byte B):
  - RGB565: {A, B}.
  - RGB444: {4'b0, A[7:4], A[2:0], B[7], B[4:1]}, i.e. top 4 bits of R, G and B.
  - Y8: {8'b0, A}.
- Decimation: a pixel is kept when col % DEC == 0 and row % DEC == 0. col counts pixels in the line; row counts lines with href.
- Pixels with col >= H_ACT or row >= V_ACT are discarded.
- Write timing: o_wr is asserted for one cycle, the cycle after byte B is sampled, with o_pix_data and o_pix_addr valid in that same cycle.
- Address sequencing: the first write of a frame uses address 0. The address increments after each write and is never written beyond (H_ACT/DEC)*(V_ACT/DEC)-1.
- Line end (HREF falling edge): if the byte count is not equal to 2*H_ACT, set o_fmt_err. The line still counts as a row.
- HREF high outside ACTIVE is ignored.
- Simultaneous i_arm and i_stop in IDLE: stop wins and the block stays in IDLE.
- A synchronous reset mid-frame aborts immediately; o_wr is 0 in the following cycle.

Decomposition:
- Shared package cam_pkg holds:
  - the mode encodings (MODE_RGB444, MODE_RGB565, MODE_Y8);
  - the state enumeration;
  - the OV7670 default geometry constants (640x480).
- One natural sub-module: cam_pix_pack. It is a combinational byte-pair-to-pixel formatter taking A, B and mode, and producing 16 bits.
- The FSM, counters and write logic stay in the top-level block.

Test Plan:
1. Params H_ACT=4, V_ACT=3, DEC=1; mode 1; arm; one frame with bytes 0x12,0x34 repeated -> 12 writes, data 0x1234, addresses 0..11, one o_frame_done, o_frame_cnt=1, block returns to IDLE.
2. Mode 0, bytes A=0xF8, B=0x1F -> o_pix_data=0x0F0F. Mode 2, A=0x80 -> 0x0080.
3. DEC=2, H_ACT=4, V_ACT=4; continuous; 3 frames -> 4 writes per frame at addresses 0..3, o_frame_cnt=3. i_stop during frame 3 -> done pulse, then IDLE.
4. A line with 7 bytes (odd count) -> o_fmt_err=1, frame still ends with o_frame_done. A frame with only 2 lines -> o_fmt_err=1, no done pulse.
5. i_arm with i_cam_done=0 -> stays in IDLE, o_busy=0. i_cam_done dropping mid-frame -> IDLE, no further o_wr, no done pulse.
6. i_rst asserted during ACTIVE mid-line -> the next cycle has all outputs 0. After re-arm, the first write uses address 0.
